// File: rtl/ir_scan_controller.sv
// ir_scan_controller: sequences the IR frequency-measurement unit, classifies each
// scan into a beacon colour, debounces it across scans and drives one-hot LEDs.
// Ports: clk/rst (async, active-low), enable, meas_done/meas_freq in; meas_clr,
// busy, color_code/color_valid and led_red/green/blue/white out (all registered).
module ir_scan_controller #(
  parameter int FREQ_W      = 32,
  parameter int NSAMP       = 3,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CONFIRM     = 2,
  parameter int RED_LO      = 800,
  parameter int RED_HI      = 1200,
  parameter int GRN_LO      = 1800,
  parameter int GRN_HI      = 2300,
  parameter int BLU_LO      = 2800,
  parameter int BLU_HI      = 3200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              meas_done,
  input  logic [FREQ_W-1:0] meas_freq,
  output logic              meas_clr,
  output logic              busy,
  output logic [1:0]        color_code,
  output logic              color_valid,
  output logic              led_red,
  output logic              led_green,
  output logic              led_blue,
  output logic              led_white
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int CW = $clog2(CONFIRM + 1);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NSAMP - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(CONFIRM);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT, S_NEXT, S_DECIDE} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic [1:0]      scan_res;     // running agreement of this scan's samples
  logic [1:0]      last_result;
  logic            shown;        // a class has been displayed since reset

  // Strict window bounds; red wins over blue, blue over green.
  function automatic logic [1:0] classify(input logic [FREQ_W-1:0] f);
    if (f > FREQ_W'(RED_LO) && f < FREQ_W'(RED_HI))      classify = 2'd1;
    else if (f > FREQ_W'(BLU_LO) && f < FREQ_W'(BLU_HI)) classify = 2'd3;
    else if (f > FREQ_W'(GRN_LO) && f < FREQ_W'(GRN_HI)) classify = 2'd2;
    else                                                  classify = 2'd0;
  endfunction

  logic [1:0]    samp_cls;
  logic          samp_end;
  logic          same;
  logic [CW-1:0] cnt_next;
  logic          show;

  // A timed-out sample counts as "no signal"; done in the timeout cycle still wins.
  assign samp_cls = meas_done ? classify(meas_freq) : 2'd0;
  assign samp_end = meas_done || (timer == T_LAST);

  always_comb begin
    same     = (scan_res == last_result);
    cnt_next = CW'(1);
    if (same) begin
      cnt_next = (cnt >= C_MAX) ? C_MAX : cnt + CW'(1);
    end
  end

  assign show = (cnt_next >= C_MAX) && (!shown || (scan_res != color_code));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      idx         <= '0;
      cnt         <= '0;
      scan_res    <= 2'd0;
      last_result <= 2'd0;
      shown       <= 1'b0;
      meas_clr    <= 1'b0;
      busy        <= 1'b0;
      color_code  <= 2'd0;
      color_valid <= 1'b0;
      led_red     <= 1'b0;
      led_green   <= 1'b0;
      led_blue    <= 1'b0;
      led_white   <= 1'b0;
    end else begin
      meas_clr    <= 1'b0;
      color_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_CLEAR;
            meas_clr <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_CLEAR: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          if (samp_end) begin
            state <= S_NEXT;
            if (idx == '0) begin
              scan_res <= samp_cls;
            end else if (samp_cls != scan_res) begin
              scan_res <= 2'd0;
            end
          end
        end
        S_NEXT: begin
          if (idx == I_LAST) begin
            idx   <= '0;
            state <= S_DECIDE;
          end else begin
            idx      <= idx + IW'(1);
            state    <= S_CLEAR;
            meas_clr <= 1'b1;
          end
        end
        S_DECIDE: begin
          cnt <= cnt_next;
          if (!same) begin
            last_result <= scan_res;
          end
          if (show) begin
            shown       <= 1'b1;
            color_code  <= scan_res;
            color_valid <= 1'b1;
            led_red     <= (scan_res == 2'd1);
            led_green   <= (scan_res == 2'd2);
            led_blue    <= (scan_res == 2'd3);
            led_white   <= (scan_res == 2'd0);
          end
          if (enable) begin
            state    <= S_CLEAR;
            meas_clr <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_scan_controller.sv
// Testbench for ir_scan_controller: a measurement-unit responder answers each
// meas_clr with a programmed frequency (or stays silent), and a scan-level model
// predicts the displayed class, LEDs and number of color_valid pulses.
module tb_ir_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        meas_done = 1'b0;
  logic [31:0] meas_freq = '0;
  logic        meas_clr, busy, color_valid;
  logic [1:0]  color_code;
  logic        led_red, led_green, led_blue, led_white;
  logic [3:0]  leds;

  assign leds = {led_white, led_blue, led_green, led_red};

  ir_scan_controller #(
    .FREQ_W(32), .NSAMP(3), .TIMEOUT_CYC(50), .CONFIRM(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .meas_done(meas_done), .meas_freq(meas_freq),
    .meas_clr(meas_clr), .busy(busy),
    .color_code(color_code), .color_valid(color_valid),
    .led_red(led_red), .led_green(led_green), .led_blue(led_blue), .led_white(led_white)
  );

  always #5 clk = ~clk;

  int vec = 0, miss = 0;
  int clr_cnt = 0, vld_cnt = 0, cyc = 0;
  int scan_cycles = 0;

  always @(negedge clk) begin
    cyc++;
    if (meas_clr) clr_cnt++;
    if (color_valid) vld_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model (scan level) ----------------
  int hist[$];
  int disp = 0;
  bit shown = 0;
  int exp_vld = 0;

  // Negative frequency stands for "unit never answers" (timeout -> no signal).
  function automatic int ref_cls(longint f);
    if (f < 0) return 0;
    if (f > 800 && f < 1200) return 1;
    if (f > 2800 && f < 3200) return 3;
    if (f > 1800 && f < 2300) return 2;
    return 0;
  endfunction

  function automatic logic [3:0] exp_leds();
    if (!shown) return 4'b0000;
    case (disp)
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic model_scan(input longint f0, input longint f1, input longint f2);
    int c0, c1, c2, res, run;
    c0 = ref_cls(f0); c1 = ref_cls(f1); c2 = ref_cls(f2);
    res = (c0 == c1 && c1 == c2) ? c0 : 0;
    hist.push_back(res);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != res) break;
      run++;
    end
    if (run >= 2 && (!shown || res != disp)) begin
      disp = res;
      shown = 1;
      exp_vld++;
    end
  endtask

  task automatic model_reset();
    hist.delete();
    disp = 0;
    shown = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_clr();
    int n = 0;
    while (!meas_clr && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("clr_arrives", {31'd0, meas_clr}, 32'd1);
  endtask

  task automatic respond(input longint f, input int d);
    wait_clr();
    if (f < 0) begin
      @(negedge clk);
    end else begin
      repeat (d) @(negedge clk);
      meas_done = 1'b1;
      meas_freq = f[31:0];
      @(negedge clk);
      meas_done = 1'b0;
      meas_freq = $urandom;
    end
  endtask

  // One full scan; d=0 picks a random response delay per sample.
  task automatic scan(input longint f0, input longint f1, input longint f2,
                      input int d, input bit drop_enable);
    longint fs[3];
    int n, t0;
    fs[0] = f0; fs[1] = f1; fs[2] = f2;
    t0 = -1;
    for (int s = 0; s < 3; s++) begin
      if (s == 0) begin
        wait_clr();
        t0 = cyc;
      end
      respond(fs[s], (d != 0) ? d : int'($urandom_range(1, 6)));
      if (s == 0 && drop_enable) enable = 1'b0;
    end
    n = 0;
    while (!(meas_clr || !busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("scan_end", {31'd0, (meas_clr || !busy)}, 32'd1);
    scan_cycles = cyc - t0;
    #1;
    model_scan(f0, f1, f2);
    chk("color_code", {30'd0, color_code}, disp);
    chk("leds", {28'd0, leds}, {28'd0, exp_leds()});
    chk("valid_pulses", vld_cnt, exp_vld);
  endtask

  longint vals[10] = '{1000, 2000, 3000, 801, 1199, 1200, 2299, 2800, 500, -1};

  initial begin
    longint v, a, b, c;
    int clr_before;

    // Reset state
    #12;
    chk("rst_code", {30'd0, color_code}, 0);
    chk("rst_leds", {28'd0, leds}, 0);
    chk("rst_busy_clr_vld", {29'd0, busy, meas_clr, color_valid}, 0);
    enable = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // 1: red, confirmed on the second scan, third scan silent
    chk("clr_before_first", clr_cnt, 0);
    scan(1000, 1000, 1000, 1, 0);
    chk("min_latency", scan_cycles, 10);
    chk("clr_per_scan", clr_cnt, 4);
    scan(1000, 1000, 1000, 0, 0);
    scan(1000, 1000, 1000, 0, 0);

    // 2: green then blue
    scan(2000, 2000, 2000, 0, 0);
    scan(2000, 2000, 2000, 0, 0);
    scan(3000, 3000, 3000, 0, 0);
    scan(3000, 3000, 3000, 0, 0);

    // 3: no signal at all -> timeouts -> white
    scan(-1, -1, -1, 0, 0);
    scan(-1, -1, -1, 0, 0);

    // 4: window boundaries and mixed scans
    scan(801, 801, 801, 0, 0);
    scan(801, 801, 801, 0, 0);
    scan(800, 800, 800, 0, 0);
    scan(1200, 1200, 1200, 0, 0);
    scan(1199, 1199, 1199, 0, 0);
    scan(1199, 1199, 1199, 0, 0);
    scan(3200, 3200, 3200, 0, 0);
    scan(3200, 3200, 3200, 0, 0);
    scan(1000, 1000, 1000, 0, 0);
    scan(1000, 1000, 1000, 0, 0);
    scan(1000, 1000, 2000, 0, 0);
    scan(1000, 1000, 2000, 0, 0);

    // 5: alternating results never confirm
    scan(1000, 1000, 1000, 0, 0);
    scan(2000, 2000, 2000, 0, 0);
    scan(1000, 1000, 1000, 0, 0);

    // done in the same cycle as the timeout must still be taken
    scan(2000, 2000, 2000, 50, 0);
    scan(2000, 2000, 2000, 50, 0);

    // 6: async reset in mid-WAIT
    wait_clr();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_code", {30'd0, color_code}, 0);
    chk("async_rst_leds", {28'd0, leds}, 0);
    chk("async_rst_busy_clr_vld", {29'd0, busy, meas_clr, color_valid}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("restart_clear", {30'd0, meas_clr, busy}, 32'd3);
    scan(3000, 3000, 3000, 0, 0);
    scan(3000, 3000, 3000, 0, 0);

    // enable dropped mid-scan: scan completes, then idle
    scan(1000, 1000, 1000, 0, 1);
    clr_before = clr_cnt;
    repeat (5) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_no_clr", clr_cnt, clr_before);
    chk("idle_hold_code", {30'd0, color_code}, disp);
    enable = 1'b1;

    // randomized scans
    v = 1000;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 9) >= 6) v = vals[$urandom_range(0, 9)];
      a = v; b = v; c = v;
      if ($urandom_range(0, 9) < 2) c = vals[$urandom_range(0, 8)];
      scan(a, b, c, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
